// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundles the register-file read, write, reservation and flush
// signals so the core-side master and the register file see one port.
//   master : drives read addresses, both write ports, reserve and flush;
//            receives read data, busy flags, reserve ack and busy count.
//   slave  : the register file side of the same signals.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wa_en;
    logic [AW-1:0]       wa_addr;
    logic [XLEN-1:0]     wa_data;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ack;
    logic                flush;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, rsv_ack, busy_cnt
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, rsv_ack, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NRD combinational read ports, two
// write ports (A: ALU/writeback, B: long-latency load/mul) and a per-register
// busy scoreboard. A register is reserved at issue and released by its
// port-B write. x0 reads as zero and is never busy.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears data, busy bits and busy count
//   bus   : regfile_sb_if slave (reads, write ports A/B, reserve, flush,
//           busy count)
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;
    logic [AW:0]         busy_cnt_q;
    logic [AW:0]         busy_cnt_d;
    logic                rsv_ack;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [AW-1:0]       rd_a;

    // Reserve is judged against the stored busy bit, so a release and a
    // reserve of the same register in one cycle is refused.
    assign rsv_ack = bus.rsv_en && (bus.rsv_addr != '0) && !busy_q[bus.rsv_addr]
                     && !bus.flush && !reset;

    // Port B is applied after port A so it wins on an address collision.
    always_comb begin
        regs_d = regs_q;
        if (bus.wa_en && (bus.wa_addr != '0)) regs_d[bus.wa_addr] = bus.wa_data;
        if (bus.wb_en && (bus.wb_addr != '0)) regs_d[bus.wb_addr] = bus.wb_data;
    end

    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (rsv_ack) busy_d[bus.rsv_addr] = 1'b1;
            if (bus.wb_en) busy_d[bus.wb_addr] = 1'b0;
        end
        busy_d[0] = 1'b0;
        busy_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_a    = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_a = bus.rd_addr[k*AW +: AW];
            if (rd_a != '0) begin
                rd_data[k*XLEN +: XLEN] = regs_q[rd_a];
                if (BYPASS != 0) begin
                    if (bus.wb_en && (bus.wb_addr == rd_a)) begin
                        rd_data[k*XLEN +: XLEN] = bus.wb_data;
                    end else if (bus.wa_en && (bus.wa_addr == rd_a)) begin
                        rd_data[k*XLEN +: XLEN] = bus.wa_data;
                    end
                end
                rd_busy[k] = busy_q[rd_a];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_busy  = rd_busy;
    assign bus.rsv_ack  = rsv_ack;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-driven bench for regfile_sb (XLEN=32, NREGS=32,
// NRD=2, BYPASS=1). Each task pushes expected values when it drives a cycle
// and pops them when it samples the DUT half a cycle later.
module tb_regfile_sb;
    logic clk;
    logic reset;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        bus.rd_addr  = '0;
        bus.wa_en    = 1'b0;
        bus.wa_addr  = '0;
        bus.wa_data  = '0;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr = {5'(31 - a), 5'(a)};
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL reset_rd0 addr %0d: got %h exp %h", a, bus.rd_data[31:0], e); end
            e = exp_q.pop_front(); n_checks++;
            if (bus.rd_data[63:32] !== e) begin n_fails++; $display("FAIL reset_rd1 addr %0d: got %h exp %h", 31 - a, bus.rd_data[63:32], e); end
            e = exp_q.pop_front(); n_checks++;
            if ({30'b0, bus.rd_busy} !== e) begin n_fails++; $display("FAIL reset_busy addr %0d: got %b exp %h", a, bus.rd_busy, e); end
        end
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL reset_cnt: got %0d exp %0d", bus.busy_cnt, e); end
    endtask

    task automatic test_bypass();
        step(); idle();
        bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'hDEADBEEF;
        bus.rd_addr = {5'd0, 5'd5};
        exp_q.push_back(32'hDEADBEEF);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL bypass_same_cycle: got %h exp %h", bus.rd_data[31:0], e); end
        step(); idle();
        bus.rd_addr = {5'd5, 5'd0};
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[63:32] !== e) begin n_fails++; $display("FAIL bypass_next_cycle: got %h exp %h", bus.rd_data[63:32], e); end
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL read_x0: got %h exp %h", bus.rd_data[31:0], e); end
    endtask

    task automatic test_port_priority();
        step(); idle();
        bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'h11;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h22;
        bus.rd_addr = {5'd7, 5'd7};
        exp_q.push_back(32'h22);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL prio_bypass: got %h exp %h", bus.rd_data[31:0], e); end
        step(); idle();
        bus.wa_en = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hFFFFFFFF;
        bus.rd_addr = {5'd0, 5'd7};
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL prio_stored: got %h exp %h", bus.rd_data[31:0], e); end
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[63:32] !== e) begin n_fails++; $display("FAIL x0_bypass: got %h exp %h", bus.rd_data[63:32], e); end
        step(); idle();
        bus.rd_addr = {5'd0, 5'd0};
        exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[63:32] !== e) begin n_fails++; $display("FAIL x0_stored: got %h exp %h", bus.rd_data[63:32], e); end
    endtask

    task automatic test_scoreboard();
        // reserve x9
        step(); idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9; bus.rd_addr = {5'd0, 5'd9};
        exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rsv_ack} !== e) begin n_fails++; $display("FAIL rsv_x9_ack: got %b exp %h", bus.rsv_ack, e); end
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rd_busy[0]} !== e) begin n_fails++; $display("FAIL rsv_x9_busy_same: got %b exp %h", bus.rd_busy[0], e); end
        // retry while busy
        step();
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rsv_ack} !== e) begin n_fails++; $display("FAIL rsv_x9_again_ack: got %b exp %h", bus.rsv_ack, e); end
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rd_busy[0]} !== e) begin n_fails++; $display("FAIL rsv_x9_busy: got %b exp %h", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL rsv_x9_cnt: got %0d exp %0d", bus.busy_cnt, e); end
        // release via port B
        step(); idle();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h1234; bus.rd_addr = {5'd0, 5'd9};
        exp_q.push_back(32'h1234); exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL rel_x9_bypass: got %h exp %h", bus.rd_data[31:0], e); end
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rd_busy[0]} !== e) begin n_fails++; $display("FAIL rel_x9_busy_same: got %b exp %h", bus.rd_busy[0], e); end
        step(); idle();
        bus.rd_addr = {5'd0, 5'd9};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1234);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rd_busy[0]} !== e) begin n_fails++; $display("FAIL rel_x9_busy: got %b exp %h", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL rel_x9_cnt: got %0d exp %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL rel_x9_data: got %h exp %h", bus.rd_data[31:0], e); end
        // release and reserve of x10 in the same cycle
        step(); idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd10;
        exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rsv_ack} !== e) begin n_fails++; $display("FAIL rsv_x10_ack: got %b exp %h", bus.rsv_ack, e); end
        step();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'hA0;
        exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rsv_ack} !== e) begin n_fails++; $display("FAIL rel_rsv_x10_ack: got %b exp %h", bus.rsv_ack, e); end
        step(); idle();
        bus.rd_addr = {5'd0, 5'd10};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rd_busy[0]} !== e) begin n_fails++; $display("FAIL rel_rsv_x10_busy: got %b exp %h", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL rel_rsv_x10_cnt: got %0d exp %0d", bus.busy_cnt, e); end
        // a port-A write leaves the busy bit alone
        step(); idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd11;
        step(); idle();
        bus.wa_en = 1'b1; bus.wa_addr = 5'd11; bus.wa_data = 32'hB0;
        step(); idle();
        bus.rd_addr = {5'd0, 5'd11};
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'hB0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rd_busy[0]} !== e) begin n_fails++; $display("FAIL wa_x11_busy: got %b exp %h", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL wa_x11_cnt: got %0d exp %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL wa_x11_data: got %h exp %h", bus.rd_data[31:0], e); end
        step(); idle();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd11; bus.wb_data = 32'hB1;
        step(); idle();
        exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL rel_x11_cnt: got %0d exp %0d", bus.busy_cnt, e); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 4; i++) begin
            step(); idle();
            bus.rsv_en = 1'b1; bus.rsv_addr = 5'(i);
            exp_q.push_back(32'h1);
            #4;
            e = exp_q.pop_front(); n_checks++;
            if ({31'b0, bus.rsv_ack} !== e) begin n_fails++; $display("FAIL flush_rsv_ack x%0d: got %b exp %h", i, bus.rsv_ack, e); end
        end
        step(); idle();
        bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd6; bus.wa_data = 32'h66;
        exp_q.push_back(32'h4); exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL flush_cnt_before: got %0d exp %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rsv_ack} !== e) begin n_fails++; $display("FAIL flush_rsv_ack: got %b exp %h", bus.rsv_ack, e); end
        step(); idle();
        bus.rd_addr = {5'd6, 5'd1};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h66);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL flush_cnt_after: got %0d exp %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rd_busy[0]} !== e) begin n_fails++; $display("FAIL flush_busy_x1: got %b exp %h", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[63:32] !== e) begin n_fails++; $display("FAIL flush_write_x6: got %h exp %h", bus.rd_data[63:32], e); end
    endtask

    task automatic test_reset_override();
        step(); idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd12;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'hAB;
        step(); idle();
        bus.rd_addr = {5'd12, 5'd3};
        exp_q.push_back(32'h1); exp_q.push_back(32'hAB); exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL pre_reset_cnt: got %0d exp %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL pre_reset_x3: got %h exp %h", bus.rd_data[31:0], e); end
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rd_busy[1]} !== e) begin n_fails++; $display("FAIL pre_reset_busy_x12: got %b exp %h", bus.rd_busy[1], e); end
        step(); idle();
        reset = 1'b1;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'h55;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h77;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd8;
        exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rsv_ack} !== e) begin n_fails++; $display("FAIL reset_rsv_ack: got %b exp %h", bus.rsv_ack, e); end
        step(); idle();
        reset = 1'b0;
        bus.rd_addr = {5'd4, 5'd3};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[31:0] !== e) begin n_fails++; $display("FAIL reset_drop_x3: got %h exp %h", bus.rd_data[31:0], e); end
        e = exp_q.pop_front(); n_checks++;
        if (bus.rd_data[63:32] !== e) begin n_fails++; $display("FAIL reset_drop_x4: got %h exp %h", bus.rd_data[63:32], e); end
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL reset_ovr_cnt: got %0d exp %0d", bus.busy_cnt, e); end
        bus.rd_addr = {5'd8, 5'd12};
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if ({30'b0, bus.rd_busy} !== e) begin n_fails++; $display("FAIL reset_ovr_busy: got %b exp %h", bus.rd_busy, e); end
        e = exp_q.pop_front(); n_checks++;
        if ({31'b0, bus.rsv_ack} !== e) begin n_fails++; $display("FAIL rsv_x0_ack: got %b exp %h", bus.rsv_ack, e); end
        step(); idle();
        exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); n_checks++;
        if ({26'b0, bus.busy_cnt} !== e) begin n_fails++; $display("FAIL rsv_x0_cnt: got %0d exp %0d", bus.busy_cnt, e); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_bypass();
        test_port_priority();
        test_scoreboard();
        test_flush();
        test_reset_override();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
